mips_mc_control: RTL and testbench
==================================

Name: mips_mc_control

Overview:
- Multi-cycle MIPS main control FSM.
- It sits on the driving side of the datapath ALU: it issues the 4-bit ALU operation code, selects the ALU operands, and consumes the ALU zero flag for beq.
- It sequences fetch, decode, execute, memory and writeback over multiple cycles, waiting on a memory-ready handshake.

Parameters:
- none (the opcode, funct and ALU operation encodings are fixed by the ISA subset and the ALU).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  6  IR[31:26]; stable from DECODE until the next FETCH.
- funct  input  6  IR[5:0].
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current access this cycle.
- pc_en  output  1  PC register load enable.
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  instruction register load.
- reg_dst  output  1  write register select: 0 = rt, 1 = rd.
- mem_to_reg  output  1  writeback select: 0 = ALUOut, 1 = MDR.
- reg_write  output  1  register file write enable.
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = A register.
- alu_src_b  output  2  ALU B select: 00 = B register, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- pc_src  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_control  output  4  ALU operation: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR.
- state_out  output  4  current state code, for debug.
- illegal  output  1  one-cycle pulse on an unsupported instruction.

Behaviour:
- Architecture:
  - One state register, updated on the rising clk edge.
  - reset asynchronously forces state RESET(0); it takes effect immediately, even mid-instruction or mid-memory-wait.
  - Outputs are combinational decode of state, plus mem_ready, zero, opcode and funct where noted.
  - Any output not listed for a state is 0, and alu_control is 0.
- States and codes: RESET 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, ALUWB 8, BRANCH 9, ADDIEX 10, ADDIWB 11, JUMP 12. Codes 13-15 are unreachable and go to FETCH.
- RESET: all outputs 0 and state_out = 0. Next state is FETCH unconditionally.
- FETCH:
  - Outputs: mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_control = 2, pc_src = 00.
  - ir_write = pc_en = mem_ready.
  - Stays in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
- DECODE:
  - Outputs: alu_src_a = 0, alu_src_b = 11, alu_control = 2 (computes the branch target).
  - Next state by opcode:
    - 0x00 → EXEC, if funct is supported.
    - 0x23 (lw) or 0x2B (sw) → MEMADR.
    - 0x04 (beq) → BRANCH.
    - 0x08 (addi) → ADDIEX.
    - 0x02 (j) → JUMP.
  - Any other opcode, or opcode 0x00 with unsupported funct: illegal = 1 this cycle, next state FETCH.
- MEMADR: alu_src_a = 1, alu_src_b = 10, alu_control = 2. Next state MEMRD for opcode 0x23, MEMWR for 0x2B.
- MEMRD: iord = 1, mem_read = 1. Stays while mem_ready = 0; goes to MEMWB when mem_ready = 1.
- MEMWB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Next state FETCH.
- MEMWR: iord = 1, mem_write = 1. Stays while mem_ready = 0; goes to FETCH when mem_ready = 1.
- EXEC:
  - Outputs: alu_src_a = 1, alu_src_b = 00.
  - alu_control from funct: 0x20 → 2, 0x22 → 6, 0x24 → 0, 0x25 → 1, 0x27 → 12, 0x2A → 7.
  - Next state ALUWB.
- ALUWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Next state FETCH.
- BRANCH:
  - Outputs: alu_src_a = 1, alu_src_b = 00, alu_control = 6, pc_src = 01.
  - pc_en = zero.
  - Next state FETCH.
- ADDIEX: alu_src_a = 1, alu_src_b = 10, alu_control = 2. Next state ADDIWB.
- ADDIWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Next state FETCH.
- JUMP: pc_src = 10, pc_en = 1. Next state FETCH.
- Latency in cycles, from FETCH entry with mem_ready = 1 every cycle:
  - R-type 4, lw 5, sw 4, beq 3, addi 4, j 3, illegal 2.
- Invariants:
  - mem_read and mem_write are never both 1.
  - reg_write and mem_write are never both 1.
  - Each instruction asserts ir_write for exactly one cycle.

Test Plan:
- Reset:
  - Assert reset mid-MEMRD → state_out = 0 and all outputs 0 immediately, with no clock edge needed.
  - Release reset → FETCH on the next edge, then mem_read = 1.
- R-type:
  - opcode = 0x00, funct = 0x22, mem_ready = 1 → states 1, 2, 7, 8, 1.
  - In EXEC, alu_control = 6; in ALUWB, reg_write = 1 and reg_dst = 1.
  - Repeat with funct 0x27 → alu_control = 12; with funct 0x2A → alu_control = 7.
- lw with wait states:
  - opcode = 0x23, mem_ready held 0 for 3 cycles in FETCH and 2 cycles in MEMRD.
  - FETCH lasts 4 cycles with ir_write = 1 only in the last; MEMRD lasts 3 cycles.
  - MEMWB has reg_write = 1 and mem_to_reg = 1.
- sw then beq:
  - sw (0x2B) → path 1, 2, 3, 6, 1, with mem_write = 1 and iord = 1 in MEMWR.
  - beq (0x04) with zero = 1 → pc_en = 1 and pc_src = 01 in BRANCH; with zero = 0 → pc_en = 0.
- addi and j:
  - 0x08 → path 1, 2, 10, 11, 1, with alu_src_b = 10 in ADDIEX and reg_dst = 0 in ADDIWB.
  - 0x02 → JUMP with pc_src = 10 and pc_en = 1.
- Illegal:
  - opcode = 0x3F, or opcode = 0x00 with funct = 0x01 → illegal = 1 for exactly the DECODE cycle.
  - Next state is FETCH, with no reg_write or mem_write asserted.

Source files
------------

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS main control FSM.
// Sequences fetch / decode / execute / memory / writeback for the subset
// R-type (add, sub, and, or, nor, slt), lw, sw, beq, addi and j.  It drives
// the ALU operation code and operand selects and consumes the ALU zero flag
// for beq.
//
// Memory handshake: in FETCH, MEMRD and MEMWR the request (mem_read or
// mem_write) is held for as long as the FSM stays in that state.  The access
// completes in the cycle where mem_ready is 1, and the FSM leaves the state on
// the following rising edge.  mem_ready is ignored in every other state.
//
// The current state code is exported on state_out for debug and checkers.
module mips_mc_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [3:0] alu_control,
    output logic [3:0] state_out,
    output logic       illegal
);

    // Opcodes of the supported instruction subset
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operation codes understood by the datapath ALU
    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    // ALU operand B selects
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // Next-PC selects
    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_OUT  = 2'b01;
    localparam logic [1:0] PCSRC_JUMP = 2'b10;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_funct_ok;
    logic [3:0] w_funct_alu;

    // State register; reset takes effect immediately, even mid-access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_next;
        end
    end

    // R-type funct decode: supported flag and matching ALU operation
    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_alu = ALU_AND;
        case (funct)
            FN_ADD:  w_funct_alu = ALU_ADD;
            FN_SUB:  w_funct_alu = ALU_SUB;
            FN_AND:  w_funct_alu = ALU_AND;
            FN_OR:   w_funct_alu = ALU_OR;
            FN_NOR:  w_funct_alu = ALU_NOR;
            FN_SLT:  w_funct_alu = ALU_SLT;
            default: w_funct_ok  = 1'b0;
        endcase
    end

    // Next-state and control output decode
    always_comb begin
        w_next      = S_FETCH;
        pc_en       = 1'b0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REG;
        pc_src      = PCSRC_ALU;
        alu_control = ALU_AND;
        illegal     = 1'b0;

        case (r_state)
            S_RESET: begin
                w_next = S_FETCH;
            end

            // Instruction read while the ALU computes PC + 4; the IR and
            // PC load together in the cycle the memory completes.
            S_FETCH: begin
                mem_read    = 1'b1;
                iord        = 1'b0;
                alu_src_a   = 1'b0;
                alu_src_b   = SRCB_FOUR;
                alu_control = ALU_ADD;
                pc_src      = PCSRC_ALU;
                ir_write    = mem_ready;
                pc_en       = mem_ready;
                w_next      = mem_ready ? S_DECODE : S_FETCH;
            end

            // Speculatively compute the branch target into ALUOut
            S_DECODE: begin
                alu_src_a   = 1'b0;
                alu_src_b   = SRCB_IMMSH;
                alu_control = ALU_ADD;
                case (opcode)
                    OP_RTYPE: begin
                        if (w_funct_ok) begin
                            w_next = S_EXEC;
                        end else begin
                            illegal = 1'b1;
                            w_next  = S_FETCH;
                        end
                    end
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        w_next  = S_FETCH;
                    end
                endcase
            end

            // Effective address = A + sign-extended offset
            S_MEMADR: begin
                alu_src_a   = 1'b1;
                alu_src_b   = SRCB_IMM;
                alu_control = ALU_ADD;
                w_next      = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end

            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                w_next   = mem_ready ? S_MEMWB : S_MEMRD;
            end

            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                reg_dst    = 1'b0;
                w_next     = S_FETCH;
            end

            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                w_next    = mem_ready ? S_FETCH : S_MEMWR;
            end

            S_EXEC: begin
                alu_src_a   = 1'b1;
                alu_src_b   = SRCB_REG;
                alu_control = w_funct_alu;
                w_next      = S_ALUWB;
            end

            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                mem_to_reg = 1'b0;
                w_next     = S_FETCH;
            end

            // Compare A and B; take the target held in ALUOut when equal
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_src_b   = SRCB_REG;
                alu_control = ALU_SUB;
                pc_src      = PCSRC_OUT;
                pc_en       = zero;
                w_next      = S_FETCH;
            end

            S_ADDIEX: begin
                alu_src_a   = 1'b1;
                alu_src_b   = SRCB_IMM;
                alu_control = ALU_ADD;
                w_next      = S_ADDIWB;
            end

            S_ADDIWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b0;
                mem_to_reg = 1'b0;
                w_next     = S_FETCH;
            end

            S_JUMP: begin
                pc_src = PCSRC_JUMP;
                pc_en  = 1'b1;
                w_next = S_FETCH;
            end

            // Unused codes 13-15 recover to FETCH with all outputs idle
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    assign state_out = r_state;

endmodule

// File: tb/tb_mips_mc_control.sv
// Testbench for mips_mc_control.
// Each instruction is expanded into an expected per-cycle trace (drive values
// for mem_ready/zero plus the expected state code and control word) from the
// instruction-level timing rules; the trace is then replayed against the DUT.
module tb_mips_mc_control;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [3:0] alu_control;
    logic [3:0] state_out;
    logic       illegal;

    mips_mc_control dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_en       (pc_en),
        .iord        (iord),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .pc_src      (pc_src),
        .alu_control (alu_control),
        .state_out   (state_out),
        .illegal     (illegal)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Observed control word, same field order as ctl()
    logic [17:0] w_obs;
    assign w_obs = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst,
                    mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src,
                    alu_control, illegal};

    // Record: {mem_ready, zero, state[3:0], ctl[17:0]}
    logic [23:0] exp_q[$];
    int          compared = 0;
    int          mism     = 0;
    int          ir_cnt   = 0;
    logic [5:0]  pend_op  = 6'h00;
    logic [5:0]  pend_f   = 6'h00;

    localparam logic [5:0] LEGAL_F [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};

    function automatic logic [17:0] ctl(input logic pe, input logic io,
                                        input logic mr, input logic mw,
                                        input logic irw, input logic rd,
                                        input logic m2r, input logic rw,
                                        input logic asa, input logic [1:0] asb,
                                        input logic [1:0] ps, input logic [3:0] alu,
                                        input logic ill);
        return {pe, io, mr, mw, irw, rd, m2r, rw, asa, asb, ps, alu, ill};
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] f);
        case (f)
            6'h20:   return 4'd2;
            6'h22:   return 4'd6;
            6'h24:   return 4'd0;
            6'h25:   return 4'd1;
            6'h27:   return 4'd12;
            6'h2A:   return 4'd7;
            default: return 4'd0;
        endcase
    endfunction

    function automatic bit funct_ok(input logic [5:0] f);
        foreach (LEGAL_F[i]) if (LEGAL_F[i] == f) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit op_legal(input logic [5:0] op);
        return (op == 6'h00) || (op == 6'h02) || (op == 6'h04) ||
               (op == 6'h08) || (op == 6'h23) || (op == 6'h2B);
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic rdy, input logic z, input logic [3:0] st,
                        input logic [17:0] c);
        exp_q.push_back({rdy, z, st, c});
    endtask

    task automatic check(input string tag, input logic [21:0] obs,
                         input logic [21:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: op=%h funct=%h observed %h expected %h",
                   tag, opcode, funct, obs, exp);
        end
    endtask

    // Fetch: waits with the read pending, then IR and PC load together
    task automatic t_fetch(input int waits);
        for (int i = 0; i < waits; i++)
            push(1'b0, rb(), 4'd1, ctl(0,0,1,0,0,0,0,0,0,2'b01,2'b00,4'd2,0));
        push(1'b1, rb(), 4'd1, ctl(1,0,1,0,1,0,0,0,0,2'b01,2'b00,4'd2,0));
    endtask

    task automatic t_decode(input logic ill);
        push(rb(), rb(), 4'd2, ctl(0,0,0,0,0,0,0,0,0,2'b11,2'b00,4'd2,ill));
    endtask

    // Build the expected trace of one instruction
    // kind: 0 R-type, 1 lw, 2 sw, 3 beq, 4 addi, 5 j, 6 bad opcode, 7 bad funct
    task automatic build_instr(input int kind, input logic [5:0] op,
                               input logic [5:0] f, input int wf, input int wm,
                               input logic z);
        pend_f = 6'($urandom);
        case (kind)
            0: begin
                pend_op = 6'h00; pend_f = f;
                t_fetch(wf); t_decode(1'b0);
                push(rb(), rb(), 4'd7, ctl(0,0,0,0,0,0,0,0,1,2'b00,2'b00,alu_of(f),0));
                push(rb(), rb(), 4'd8, ctl(0,0,0,0,0,1,0,1,0,2'b00,2'b00,4'd0,0));
            end
            1: begin
                pend_op = 6'h23;
                t_fetch(wf); t_decode(1'b0);
                push(rb(), rb(), 4'd3, ctl(0,0,0,0,0,0,0,0,1,2'b10,2'b00,4'd2,0));
                for (int i = 0; i < wm; i++)
                    push(1'b0, rb(), 4'd4, ctl(0,1,1,0,0,0,0,0,0,2'b00,2'b00,4'd0,0));
                push(1'b1, rb(), 4'd4, ctl(0,1,1,0,0,0,0,0,0,2'b00,2'b00,4'd0,0));
                push(rb(), rb(), 4'd5, ctl(0,0,0,0,0,0,1,1,0,2'b00,2'b00,4'd0,0));
            end
            2: begin
                pend_op = 6'h2B;
                t_fetch(wf); t_decode(1'b0);
                push(rb(), rb(), 4'd3, ctl(0,0,0,0,0,0,0,0,1,2'b10,2'b00,4'd2,0));
                for (int i = 0; i < wm; i++)
                    push(1'b0, rb(), 4'd6, ctl(0,1,0,1,0,0,0,0,0,2'b00,2'b00,4'd0,0));
                push(1'b1, rb(), 4'd6, ctl(0,1,0,1,0,0,0,0,0,2'b00,2'b00,4'd0,0));
            end
            3: begin
                pend_op = 6'h04;
                t_fetch(wf); t_decode(1'b0);
                push(rb(), z, 4'd9, ctl(z,0,0,0,0,0,0,0,1,2'b00,2'b01,4'd6,0));
            end
            4: begin
                pend_op = 6'h08;
                t_fetch(wf); t_decode(1'b0);
                push(rb(), rb(), 4'd10, ctl(0,0,0,0,0,0,0,0,1,2'b10,2'b00,4'd2,0));
                push(rb(), rb(), 4'd11, ctl(0,0,0,0,0,0,0,1,0,2'b00,2'b00,4'd0,0));
            end
            5: begin
                pend_op = 6'h02;
                t_fetch(wf); t_decode(1'b0);
                push(rb(), rb(), 4'd12, ctl(1,0,0,0,0,0,0,0,0,2'b00,2'b10,4'd0,0));
            end
            6: begin
                pend_op = op;
                t_fetch(wf); t_decode(1'b1);
            end
            default: begin
                pend_op = 6'h00; pend_f = f;
                t_fetch(wf); t_decode(1'b1);
            end
        endcase
    endtask

    // Replay up to n_max records (all when n_max < 0), one per clock cycle
    task automatic run_trace(input int n_max);
        int          n = 0;
        logic [23:0] rec;
        while (exp_q.size() > 0 && (n_max < 0 || n < n_max)) begin
            rec = exp_q.pop_front();
            @(negedge clk);
            opcode    = pend_op;
            funct     = pend_f;
            mem_ready = rec[23];
            zero      = rec[22];
            #1;
            check("cycle", {state_out, w_obs}, rec[21:0]);
            check("rd_wr_excl", {21'd0, mem_read & mem_write}, 22'd0);
            check("rw_wr_excl", {21'd0, reg_write & mem_write}, 22'd0);
            if (ir_write) ir_cnt++;
            n++;
        end
    endtask

    task automatic do_instr(input int kind, input logic [5:0] op,
                            input logic [5:0] f, input int wf, input int wm,
                            input logic z);
        build_instr(kind, op, f, wf, wm, z);
        ir_cnt = 0;
        run_trace(-1);
        check("ir_once", 22'(ir_cnt), 22'd1);
    endtask

    initial begin
        int          kind;
        logic [5:0]  rop;
        logic [5:0]  rf;

        reset     = 1'b1;
        opcode    = 6'h00;
        funct     = 6'h00;
        zero      = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check("reset_idle", {state_out, w_obs}, 22'd0);
        reset = 1'b0;

        // Directed instructions
        do_instr(0, 6'h00, 6'h22, 0, 0, 1'b0);
        do_instr(0, 6'h00, 6'h27, 0, 0, 1'b0);
        do_instr(0, 6'h00, 6'h2A, 0, 0, 1'b0);
        do_instr(1, 6'h00, 6'h00, 3, 2, 1'b0);
        do_instr(2, 6'h00, 6'h00, 0, 0, 1'b0);
        do_instr(3, 6'h00, 6'h00, 0, 0, 1'b1);
        do_instr(3, 6'h00, 6'h00, 0, 0, 1'b0);
        do_instr(4, 6'h00, 6'h00, 0, 0, 1'b0);
        do_instr(5, 6'h00, 6'h00, 0, 0, 1'b0);
        do_instr(6, 6'h3F, 6'h00, 0, 0, 1'b0);
        do_instr(7, 6'h00, 6'h01, 0, 0, 1'b0);
        do_instr(2, 6'h00, 6'h00, 1, 3, 1'b0);

        // Randomized instruction stream with random wait states
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 7);
            rop  = 6'($urandom);
            while (op_legal(rop)) rop = 6'($urandom);
            rf = LEGAL_F[$urandom_range(0, 5)];
            if (kind == 7) begin
                rf = 6'($urandom);
                while (funct_ok(rf)) rf = 6'($urandom);
            end
            do_instr(kind, rop, rf, $urandom_range(0, 3), $urandom_range(0, 3), rb());
        end

        // Reset asserted while lw waits in MEMRD
        build_instr(1, 6'h00, 6'h00, 0, 5, 1'b0);
        run_trace(4);
        exp_q.delete();
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("pre_reset_memrd", {state_out, w_obs},
              {4'd4, ctl(0,1,1,0,0,0,0,0,0,2'b00,2'b00,4'd0,0)});
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", {state_out, w_obs}, 22'd0);
        @(posedge clk);
        #1;
        check("reset_hold", {state_out, w_obs}, 22'd0);
        reset = 1'b0;
        push(rb(), rb(), 4'd0, 18'd0);
        do_instr(5, 6'h00, 6'h00, 0, 0, 1'b0);
        do_instr(0, 6'h00, 6'h20, 2, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
